writeback_arbiter: RTL and testbench

Write-back stage that sits directly upstream of the 32x32 integer/float register file and owns its single write port. Merges results from the single-cycle ALU path (port A, fixed priority) and the multi-cycle unit path (port B, valid/ready, buffered in a small FIFO). Produces at most one registered register-file write per cycle. Exports per-register pending-write scoreboards so decode can stall on outstanding long-latency results.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 77 +++++++
 rtl/writeback_arbiter.sv | 142 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter and its result FIFO.
package wb_pkg;

  localparam int REG_W     = 5;
  localparam int RF_ADDR_W = 6;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic              valid;
    logic              killed;
    logic              is_float;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Integer register 0 is hard-wired to zero and must never be written.
  function automatic logic is_int_r0(input logic is_float, input logic [REG_W-1:0] rd);
    return !is_float && (rd == '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of write-back entries for the multi-cycle port.
// Every slot can be killed individually and exposes its target so the
// parent can build the pending-write scoreboards.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_push,
  input  wb_entry_t                   i_push_entry,
  input  logic                        i_pop,
  input  logic [DEPTH-1:0]            i_kill,
  output wb_entry_t                   o_head,
  output logic [$clog2(DEPTH)-1:0]    o_head_idx,
  output logic                        o_empty,
  output logic                        o_full,
  output logic [$clog2(DEPTH):0]      o_count,
  output logic [DEPTH-1:0]            o_live,
  output logic [DEPTH-1:0]            o_is_float,
  output logic [DEPTH-1:0][REG_W-1:0] o_rd
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  wb_entry_t   w_slot [DEPTH];

  assign o_head_idx = r_rd_ptr[AW-1:0];
  assign o_head     = w_slot[o_head_idx];
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count    = r_wr_ptr - r_rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      wb_entry_t r_entry;
      logic      w_push_here;
      logic      w_pop_here;

      assign w_push_here = i_push && (r_wr_ptr[AW-1:0] == AW'(gi));
      assign w_pop_here  = i_pop  && (o_head_idx == AW'(gi));

      // A push overwrites the whole slot; otherwise a pop retires it and a kill marks it dead.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_entry <= '0;
        end else if (w_push_here) begin
          r_entry <= i_push_entry;
        end else begin
          if (w_pop_here) r_entry.valid  <= 1'b0;
          if (i_kill[gi]) r_entry.killed <= 1'b1;
        end
      end

      assign w_slot[gi]     = r_entry;
      assign o_live[gi]     = r_entry.valid && !r_entry.killed;
      assign o_is_float[gi] = r_entry.is_float;
      assign o_rd[gi]       = r_entry.rd;
    end
  endgenerate

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back arbiter owning the single register-file write port.
// ALU results (port A) always win; multi-cycle results (port B) queue in a
// FIFO and drain on cycles without ALU traffic. A younger ALU write squashes
// queued writes to the same register, and the live queue contents drive the
// per-register pending-write scoreboards used by decode.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic                     a_float,
  input  logic [REG_W-1:0]         a_reg,
  input  logic [DATA_W-1:0]        a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic                     b_float,
  input  logic [REG_W-1:0]         b_reg,
  input  logic [DATA_W-1:0]        b_data,
  output logic                     wb_write,
  output logic                     wb_float,
  output logic [RF_ADDR_W-1:0]     wb_reg,
  output logic [DATA_W-1:0]        wb_data,
  output logic [31:0]              busy_i,
  output logic [31:0]              busy_f,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = wb_pkg::DATA_W;

  wb_entry_t                   w_push_entry;
  wb_entry_t                   w_head;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_empty;
  logic                        w_full;
  logic [AW-1:0]               w_head_idx;
  logic [DEPTH-1:0]            w_kill;
  logic [DEPTH-1:0]            w_retire;
  logic [DEPTH-1:0]            w_live;
  logic [DEPTH-1:0]            w_is_float;
  logic [DEPTH-1:0][REG_W-1:0] w_rd;

  logic                        w_sel_write;
  logic                        w_sel_float;
  logic [REG_W-1:0]            w_sel_rd;
  logic [DATA_W-1:0]           w_sel_data;

  logic                        r_wb_write;
  logic                        r_wb_float;
  logic [REG_W-1:0]            r_wb_rd;
  logic [DATA_W-1:0]           r_wb_data;

  // Ready is purely !full so the upstream handshake never depends on this cycle's pop.
  assign b_ready      = !w_full && !reset;
  assign w_push       = b_valid && b_ready;
  assign w_pop        = !a_valid && !w_empty;
  assign w_push_entry = '{valid: 1'b1, killed: 1'b0, is_float: b_float,
                          rd: b_reg, data: EW'(b_data)};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_kill       (w_kill),
    .o_head       (w_head),
    .o_head_idx   (w_head_idx),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .o_count      (fifo_count),
    .o_live       (w_live),
    .o_is_float   (w_is_float),
    .o_rd         (w_rd)
  );

  // An ALU write makes any older queued write to the same register obsolete.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_squash
      assign w_kill[gi]   = a_valid && w_live[gi] &&
                            (w_is_float[gi] == a_float) && (w_rd[gi] == a_reg);
      assign w_retire[gi] = w_kill[gi] || (w_pop && (w_head_idx == AW'(gi)));
    end
  endgenerate

  // Scoreboards drop an entry in the same cycle it is popped or squashed.
  always_comb begin
    busy_i = '0;
    busy_f = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live[i] && !w_retire[i]) begin
        if (w_is_float[i])                     busy_f[w_rd[i]] = 1'b1;
        else if (!is_int_r0(1'b0, w_rd[i]))    busy_i[w_rd[i]] = 1'b1;
      end
    end
  end

  // Source selection: A first, else FIFO head, else hold the last address/data.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_float = r_wb_float;
    w_sel_rd    = r_wb_rd;
    w_sel_data  = r_wb_data;
    if (a_valid) begin
      w_sel_write = !is_int_r0(a_float, a_reg);
      w_sel_float = a_float;
      w_sel_rd    = a_reg;
      w_sel_data  = a_data;
    end else if (w_pop) begin
      w_sel_write = w_head.valid && !w_head.killed && !is_int_r0(w_head.is_float, w_head.rd);
      w_sel_float = w_head.is_float;
      w_sel_rd    = w_head.rd;
      w_sel_data  = DATA_W'(w_head.data);
    end
  end

  // Register-file write port registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_write <= 1'b0;
      r_wb_float <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_write <= w_sel_write;
      r_wb_float <= w_sel_float;
      r_wb_rd    <= w_sel_rd;
      r_wb_data  <= w_sel_data;
    end
  end

  assign wb_write = r_wb_write;
  assign wb_float = r_wb_float;
  assign wb_reg   = {1'b0, r_wb_rd};
  assign wb_data  = r_wb_data;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus a randomized run,
// all checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_writeback_arbiter;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_valid, a_float;
  logic [4:0]        a_reg;
  logic [DATA_W-1:0] a_data;
  logic              b_valid, b_ready, b_float;
  logic [4:0]        b_reg;
  logic [DATA_W-1:0] b_data;
  logic              wb_write, wb_float;
  logic [5:0]        wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic [31:0]       busy_i, busy_f;
  logic [CW-1:0]     fifo_count;

  writeback_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_float(a_float), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_float(b_float), .b_reg(b_reg), .b_data(b_data),
    .wb_write(wb_write), .wb_float(wb_float), .wb_reg(wb_reg), .wb_data(wb_data),
    .busy_i(busy_i), .busy_f(busy_f), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of queued results.
  typedef struct { bit f; bit [4:0] r; bit [31:0] d; bit k; } ment_t;
  ment_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Observed / expected values just before the edge (combinational outputs).
  logic        cap_ready;
  logic [31:0] cap_bi, cap_bf;
  logic [CW-1:0] cap_count;
  bit          exp_ready;
  bit [31:0]   exp_bi, exp_bf;
  int          exp_count_pre;
  // Expected values just after the edge.
  bit          exp_write, exp_float;
  bit [4:0]    exp_reg;
  bit [31:0]   exp_data;
  int          exp_count;

  task automatic model_reset();
    q.delete();
    exp_write = 0; exp_float = 0; exp_reg = 0; exp_data = 0; exp_count = 0;
  endtask

  // One clock cycle: drive at negedge, sample combinational outputs, then the edge.
  task automatic step(input bit av, input bit af, input bit [4:0] ar, input bit [31:0] ad,
                      input bit bv, input bit bf, input bit [4:0] br, input bit [31:0] bd);
    bit    push;
    ment_t h;
    @(negedge clk);
    a_valid = av; a_float = af; a_reg = ar; a_data = ad;
    b_valid = bv; b_float = bf; b_reg = br; b_data = bd;
    #1;
    cap_ready = b_ready; cap_bi = busy_i; cap_bf = busy_f; cap_count = fifo_count;
    exp_ready     = (q.size() < DEPTH);
    exp_count_pre = q.size();
    exp_bi = 0; exp_bf = 0;
    foreach (q[k]) begin
      if (q[k].k) continue;
      if (av && q[k].f == af && q[k].r == ar) continue;
      if (!av && k == 0) continue;
      if (q[k].f) exp_bf[q[k].r] = 1'b1;
      else if (q[k].r != 0) exp_bi[q[k].r] = 1'b1;
    end
    push = bv && exp_ready;
    @(posedge clk);
    if (av) begin
      exp_write = !(!af && ar == 0);
      exp_float = af; exp_reg = ar; exp_data = ad;
      foreach (q[k]) if (q[k].f == af && q[k].r == ar) q[k].k = 1'b1;
    end else if (q.size() > 0) begin
      h = q.pop_front();
      exp_write = !h.k && !(!h.f && h.r == 0);
      exp_float = h.f; exp_reg = h.r; exp_data = h.d;
    end else begin
      exp_write = 0;
    end
    if (push) q.push_back('{f: bf, r: br, d: bd, k: 1'b0});
    exp_count = q.size();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_valid = 0; a_float = 0; a_reg = 0; a_data = 0;
    b_valid = 0; b_float = 0; b_reg = 0; b_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", b_ready); end
    n_checks++;
    if ({wb_write, wb_float, wb_reg, wb_data} !== '0) begin
      n_fail++; $display("FAIL reset_wb: got w=%b f=%b r=%0d d=%h expected all 0", wb_write, wb_float, wb_reg, wb_data);
    end
    n_checks++;
    if (fifo_count !== '0 || busy_i !== '0 || busy_f !== '0) begin
      n_fail++; $display("FAIL reset_fifo: got cnt=%0d bi=%h bf=%h expected 0", fifo_count, busy_i, busy_f);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (b_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b expected 1", b_ready); end
  endtask

  task automatic test_alu_write();
    step(1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    n_checks++;
    if (wb_write !== 1'b1 || wb_reg !== 6'd5 || wb_float !== 1'b0 || wb_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL alu_write: got w=%b f=%b r=%0d d=%h expected w=1 f=0 r=5 d=deadbeef", wb_write, wb_float, wb_reg, wb_data);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (wb_write !== 1'b0 || wb_reg !== 6'd5 || wb_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL alu_idle_hold: got w=%b r=%0d d=%h expected w=0 r=5 d=deadbeef", wb_write, wb_reg, wb_data);
    end
  endtask

  task automatic test_fill_drain();
    // A writes to integer r0 are no-ops, so they hold off draining while the FIFO fills.
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, 0, 32'h0, 1, 0, 5'(k), 32'(k * 16));
      n_checks++;
      if (cap_ready !== 1'b1 || wb_write !== 1'b0) begin
        n_fail++; $display("FAIL fill_%0d: got ready=%b w=%b expected ready=1 w=0", k, cap_ready, wb_write);
      end
    end
    step(1, 0, 0, 32'h0, 1, 0, 9, 32'h99);
    n_checks++;
    if (cap_ready !== 1'b0 || cap_bi !== 32'h1E || cap_count !== CW'(4)) begin
      n_fail++; $display("FAIL full_state: got ready=%b bi=%h cnt=%0d expected ready=0 bi=1e cnt=4", cap_ready, cap_bi, cap_count);
    end
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0, (k == 1), 0, 9, 32'h99);
      n_checks++;
      if (cap_ready !== exp_ready || cap_bi !== exp_bi) begin
        n_fail++; $display("FAIL drain_pre_%0d: got ready=%b bi=%h expected ready=%b bi=%h", k, cap_ready, cap_bi, exp_ready, exp_bi);
      end
      n_checks++;
      if (wb_write !== 1'b1 || wb_reg !== 6'(k) || wb_data !== 32'(k * 16) || fifo_count !== CW'(4 - k)) begin
        n_fail++; $display("FAIL drain_%0d: got w=%b r=%0d d=%h cnt=%0d expected w=1 r=%0d d=%h cnt=%0d",
                           k, wb_write, wb_reg, wb_data, fifo_count, k, k * 16, 4 - k);
      end
    end
  endtask

  task automatic test_squash();
    step(0, 0, 0, 0, 1, 1, 7, 32'h3F800000);
    step(1, 1, 7, 32'h40000000, 0, 0, 0, 0);
    n_checks++;
    if (cap_bf !== 32'h0) begin n_fail++; $display("FAIL squash_busy: got bf=%h expected 0", cap_bf); end
    n_checks++;
    if (wb_write !== 1'b1 || wb_float !== 1'b1 || wb_reg !== 6'd7 || wb_data !== 32'h40000000) begin
      n_fail++; $display("FAIL squash_a: got w=%b f=%b r=%0d d=%h expected w=1 f=1 r=7 d=40000000", wb_write, wb_float, wb_reg, wb_data);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (wb_write !== 1'b0 || fifo_count !== '0) begin
      n_fail++; $display("FAIL squash_drain: got w=%b cnt=%0d expected w=0 cnt=0", wb_write, fifo_count);
    end
  endtask

  task automatic test_a_priority();
    step(1, 0, 31, 32'h111, 1, 0, 9, 32'h55);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 5'(10 + k), 32'(32'hA0 + k), 0, 0, 0, 0);
      n_checks++;
      if (cap_bi !== 32'h200 || cap_count !== CW'(1)) begin
        n_fail++; $display("FAIL prio_busy_%0d: got bi=%h cnt=%0d expected bi=200 cnt=1", k, cap_bi, cap_count);
      end
      n_checks++;
      if (wb_write !== 1'b1 || wb_reg !== 6'(10 + k) || wb_data !== 32'(32'hA0 + k) || fifo_count !== CW'(1)) begin
        n_fail++; $display("FAIL prio_a_%0d: got w=%b r=%0d d=%h cnt=%0d expected w=1 r=%0d d=%h cnt=1",
                           k, wb_write, wb_reg, wb_data, fifo_count, 10 + k, 32'hA0 + k);
      end
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (wb_write !== 1'b1 || wb_reg !== 6'd9 || wb_data !== 32'h55 || fifo_count !== '0) begin
      n_fail++; $display("FAIL prio_drain: got w=%b r=%0d d=%h cnt=%0d expected w=1 r=9 d=55 cnt=0", wb_write, wb_reg, wb_data, fifo_count);
    end
  endtask

  task automatic test_reg0();
    step(1, 0, 0, 32'hAAAA, 0, 0, 0, 0);
    n_checks++;
    if (wb_write !== 1'b0) begin n_fail++; $display("FAIL r0_a: got w=%b expected 0", wb_write); end
    step(1, 0, 31, 32'h1, 1, 0, 0, 32'hBBBB);
    step(1, 0, 30, 32'h2, 0, 0, 0, 0);
    n_checks++;
    if (cap_bi !== 32'h0 || cap_count !== CW'(1)) begin
      n_fail++; $display("FAIL r0_busy: got bi=%h cnt=%0d expected bi=0 cnt=1", cap_bi, cap_count);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (wb_write !== 1'b0 || fifo_count !== '0) begin
      n_fail++; $display("FAIL r0_b: got w=%b cnt=%0d expected w=0 cnt=0", wb_write, fifo_count);
    end
    step(1, 1, 0, 32'h3F, 0, 0, 0, 0);
    n_checks++;
    if (wb_write !== 1'b1 || wb_float !== 1'b1 || wb_reg !== 6'd0 || wb_data !== 32'h3F) begin
      n_fail++; $display("FAIL f0_write: got w=%b f=%b r=%0d d=%h expected w=1 f=1 r=0 d=3f", wb_write, wb_float, wb_reg, wb_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 40, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
           $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      n_checks++;
      if (cap_ready !== exp_ready || cap_bi !== exp_bi || cap_bf !== exp_bf || cap_count !== CW'(exp_count_pre)) begin
        n_fail++; $display("FAIL rand_comb cyc %0d: got rdy=%b bi=%h bf=%h cnt=%0d expected rdy=%b bi=%h bf=%h cnt=%0d",
                           i, cap_ready, cap_bi, cap_bf, cap_count, exp_ready, exp_bi, exp_bf, exp_count_pre);
      end
      n_checks++;
      if (wb_write !== exp_write || fifo_count !== CW'(exp_count) || wb_reg[5] !== 1'b0) begin
        n_fail++; $display("FAIL rand_wb cyc %0d: got w=%b cnt=%0d r=%0d expected w=%b cnt=%0d", i, wb_write, fifo_count, wb_reg, exp_write, exp_count);
      end
      if (exp_write) begin
        n_checks++;
        if (wb_float !== exp_float || wb_reg !== {1'b0, exp_reg} || wb_data !== exp_data) begin
          n_fail++; $display("FAIL rand_fields cyc %0d: got f=%b r=%0d d=%h expected f=%b r=%0d d=%h",
                             i, wb_float, wb_reg, wb_data, exp_float, exp_reg, exp_data);
        end
      end
    end
    // Let the queue empty so the next scenario starts clean.
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 1, 0, 5'(11 + k), 32'(32'hC0 + k));
    step(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (wb_write !== 1'b0 || fifo_count !== '0 || busy_i !== '0 || busy_f !== '0 || b_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset: got w=%b cnt=%0d bi=%h bf=%h rdy=%b expected all 0",
                         wb_write, fifo_count, busy_i, busy_f, b_ready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (wb_write !== 1'b0 || fifo_count !== '0) begin
        n_fail++; $display("FAIL post_reset_%0d: got w=%b cnt=%0d expected w=0 cnt=0", k, wb_write, fifo_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_fill_drain();
    test_squash();
    test_a_priority();
    test_reg0();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
